// File: rtl/mem_access_pkg.sv
// Shared encodings and lane helpers for the MEM-stage load/store unit.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        DONE   = 2'b11
    } state_t;

    // Byte-lane mask (little-endian) touched by an access of the given size.
    function automatic logic [3:0] lane_sel(input logic [1:0] addr_lo, input logic [1:0] size);
        case (size)
            SZ_BYTE: lane_sel = 4'b0001 << addr_lo;
            SZ_HALF: lane_sel = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: lane_sel = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response handshake plus the word-wide data memory bus.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        misalign;
    logic        MemRd;
    logic        MemWr;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic [31:0] RdData;

    // The access unit: accepts requests, drives the memory bus.
    modport slave (
        input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, RdData,
        output req_ready, rsp_valid, rsp_rdata, misalign, MemRd, MemWr, Addr, WrData
    );

    // The pipeline and memory seen together from the outside.
    modport master (
        output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, RdData,
        input  req_ready, rsp_valid, rsp_rdata, misalign, MemRd, MemWr, Addr, WrData
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane handling: load extract/extend and sub-word store merge.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rd_data,
    input  logic [15:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [3:0]         be;
    logic [31:0]        wrep;

    // Pick the addressed lane and extend it to a full word.
    always_comb begin
        byte_s    = rd_data[{addr_lo, 3'b000} +: 8];
        half_s    = addr_lo[1] ? rd_data[31:16] : rd_data[15:0];
        load_data = rd_data;
        case (size)
            SZ_BYTE: load_data = is_signed ? 32'(byte_s) : {24'h0, byte_s};
            SZ_HALF: load_data = is_signed ? 32'(half_s) : {16'h0, half_s};
            default: load_data = rd_data;
        endcase
    end

    // Replicate store data across lanes, then take only the addressed lanes.
    always_comb begin
        be     = lane_sel(addr_lo, size);
        wrep   = (size == SZ_BYTE) ? {4{wdata[7:0]}} : {2{wdata[15:0]}};
        merged = rd_data;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? wrep[8*i +: 8] : rd_data[8*i +: 8];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator; sub-word stores become read-modify-write.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter bit RMW_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);

    state_t      state;
    logic        wr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] merged_q;
    logic        misalign_q;

    logic [1:0]  req_sz;
    logic        req_mis;
    logic        word_store;
    logic [31:0] load_data;
    logic [31:0] merged;

    // Size 11 folds into word; reject misaligned or unsupported sub-word stores.
    always_comb begin
        req_sz  = (bus.req_size == SZ_BYTE || bus.req_size == SZ_HALF) ? bus.req_size : SZ_WORD;
        req_mis = (req_sz == SZ_HALF && bus.req_addr[0]) ||
                  (req_sz == SZ_WORD && bus.req_addr[1:0] != 2'b00) ||
                  (bus.req_wr && req_sz != SZ_WORD && !RMW_EN);
    end

    mem_lane_align u_align (
        .rd_data   (bus.RdData),
        .wdata     (wdata_q[15:0]),
        .addr_lo   (addr_q[1:0]),
        .size      (size_q),
        .is_signed (signed_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // Request latch and access sequencing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            signed_q   <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            merged_q   <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        wr_q       <= bus.req_wr;
                        size_q     <= req_sz;
                        signed_q   <= bus.req_signed;
                        addr_q     <= bus.req_addr;
                        wdata_q    <= bus.req_wdata;
                        rdata_q    <= 32'h0;
                        merged_q   <= 32'h0;
                        misalign_q <= req_mis;
                        state      <= req_mis ? DONE : ACCESS;
                    end
                end
                ACCESS: begin
                    if (!wr_q) begin
                        rdata_q <= load_data;
                        state   <= DONE;
                    end else if (size_q == SZ_WORD) begin
                        state   <= DONE;
                    end else begin
                        merged_q <= merged;
                        state    <= WRITE;
                    end
                end
                WRITE:   state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and memory bus decoded purely from registered state.
    always_comb begin
        word_store    = wr_q && (size_q == SZ_WORD);
        bus.req_ready = (state == IDLE);
        bus.rsp_valid = (state == DONE);
        bus.rsp_rdata = (state == DONE) ? rdata_q : 32'h0;
        bus.misalign  = (state == DONE) && misalign_q;
        bus.MemRd     = (state == ACCESS) && !word_store;
        bus.MemWr     = ((state == ACCESS) && word_store) || (state == WRITE);
        bus.Addr      = (state == ACCESS || state == WRITE) ? {addr_q[31:2], 2'b00} : 32'h0;
        bus.WrData    = 32'h0;
        if (state == WRITE)
            bus.WrData = merged_q;
        else if (state == ACCESS && word_store)
            bus.WrData = wdata_q;
    end

endmodule
